// File: rtl/goertzel_tone_detect_pkg.sv
// goertzel_tone_detect_pkg: detector FSM state encoding and default thresholds
package goertzel_tone_detect_pkg;
  typedef enum logic [1:0] {
    ST_ABSENT   = 2'd0,
    ST_PEND_ON  = 2'd1,
    ST_PRESENT  = 2'd2,
    ST_PEND_OFF = 2'd3
  } tone_state_e;
  localparam logic [15:0] DEF_THRESH_ON  = 16'd800;
  localparam logic [15:0] DEF_THRESH_OFF = 16'd400;
endpackage

// File: rtl/goertzel_tone_detect_ema.sv
// mag_ema: shift-based exponential moving average of the magnitude stream
module mag_ema #(
  parameter int M_W      = 16,
  parameter int ALPHA_SH = 2
) (
  input  logic           i_sys_clk,
  input  logic           i_rst,
  input  logic [M_W-1:0] i_mag_in,
  input  logic           i_mag_rdy,
  output logic [M_W-1:0] o_mag_avg,
  output logic           o_avg_valid
);
  logic                  r_seeded;
  logic signed [M_W:0]   w_d;
  logic        [M_W-1:0] w_next;
  assign w_d = $signed({1'b0, i_mag_in}) - $signed({1'b0, o_mag_avg});
  // The floored step keeps the true sum inside [0, 2^M_W-1], so modulo-M_W addition is exact
  assign w_next = o_mag_avg + M_W'(w_d >>> ALPHA_SH);
  always_ff @(posedge i_sys_clk)
    if (i_rst) begin
      o_mag_avg   <= '0;
      o_avg_valid <= 1'b0;
      r_seeded    <= 1'b0;
    end else begin
      o_avg_valid <= i_mag_rdy;
      if (i_mag_rdy) begin
        o_mag_avg <= r_seeded ? w_next : i_mag_in;
        r_seeded  <= 1'b1;
      end
    end
endmodule

// File: rtl/goertzel_tone_detect.sv
// goertzel_tone_detect: EMA-smoothed hysteresis/debounce tone detector; TONE_DETECT_PEAK_EN adds o_mag_peak
module goertzel_tone_detect
  import goertzel_tone_detect_pkg::*;
#(
  parameter int M_W        = 16,
  parameter int ALPHA_SH   = 2,
  parameter int ON_FRAMES  = 3,
  parameter int OFF_FRAMES = 3,
  parameter int CNT_W      = 4
) (
  input  logic           i_sys_clk,
  input  logic           i_rst,
  input  logic [M_W-1:0] i_mag_in,
  input  logic           i_mag_rdy,
  input  logic [M_W-1:0] i_thresh_on,
  input  logic [M_W-1:0] i_thresh_off,
  output logic [M_W-1:0] o_mag_avg,
  output logic           o_avg_valid,
  output logic           o_tone_present,
  output logic           o_tone_rise,
  output logic           o_tone_fall
`ifdef TONE_DETECT_PEAK_EN
  ,
  output logic [M_W-1:0] o_mag_peak
`endif
);
  tone_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise, r_fall;
  logic [M_W-1:0]   w_eff_off;
  logic             w_above, w_below, w_to_present, w_to_absent;
  mag_ema #(.M_W(M_W), .ALPHA_SH(ALPHA_SH)) u_ema (
    .i_sys_clk  (i_sys_clk),
    .i_rst      (i_rst),
    .i_mag_in   (i_mag_in),
    .i_mag_rdy  (i_mag_rdy),
    .o_mag_avg  (o_mag_avg),
    .o_avg_valid(o_avg_valid)
  );
  // An inverted threshold pair collapses to a single threshold at i_thresh_on
  assign w_eff_off = (i_thresh_off < i_thresh_on) ? i_thresh_off : i_thresh_on;
  assign w_above   = o_mag_avg >= i_thresh_on;
  assign w_below   = o_mag_avg < w_eff_off;
  assign w_to_present = o_avg_valid && w_above &&
                        ((r_state == ST_ABSENT && ON_FRAMES == 1) ||
                         (r_state == ST_PEND_ON && r_cnt == CNT_W'(ON_FRAMES - 1)));
  assign w_to_absent  = o_avg_valid && w_below &&
                        ((r_state == ST_PRESENT && OFF_FRAMES == 1) ||
                         (r_state == ST_PEND_OFF && r_cnt == CNT_W'(OFF_FRAMES - 1)));
  always_ff @(posedge i_sys_clk)
    if (i_rst) begin
      r_state <= ST_ABSENT;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_to_present;
      r_fall <= w_to_absent;
      if (o_avg_valid)
        case (r_state)
          ST_ABSENT: begin
            r_cnt   <= w_above ? CNT_W'(1) : '0;
            r_state <= w_to_present ? ST_PRESENT : w_above ? ST_PEND_ON : ST_ABSENT;
          end
          ST_PEND_ON: begin
            r_cnt   <= (w_above && !w_to_present) ? r_cnt + 1'b1 : '0;
            r_state <= w_to_present ? ST_PRESENT : w_above ? ST_PEND_ON : ST_ABSENT;
          end
          ST_PRESENT: begin
            r_cnt   <= w_below ? CNT_W'(1) : '0;
            r_state <= w_to_absent ? ST_ABSENT : w_below ? ST_PEND_OFF : ST_PRESENT;
          end
          default: begin
            r_cnt   <= (w_below && !w_to_absent) ? r_cnt + 1'b1 : '0;
            r_state <= w_to_absent ? ST_ABSENT : w_below ? ST_PEND_OFF : ST_PRESENT;
          end
        endcase
    end
  assign o_tone_present = (r_state == ST_PRESENT) || (r_state == ST_PEND_OFF);
  assign o_tone_rise    = r_rise;
  assign o_tone_fall    = r_fall;
`ifdef TONE_DETECT_PEAK_EN
  // Peak restarts at each new tone burst
  always_ff @(posedge i_sys_clk)
    if (i_rst || w_to_present) o_mag_peak <= '0;
    else if (o_avg_valid && o_mag_avg > o_mag_peak) o_mag_peak <= o_mag_avg;
`endif
endmodule
